// File: rtl/uart_pkg.sv
// Shared UART constants: oversample rate, default frame length and the
// arbiter state encoding.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [2:0] ST_HOLD      = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_SEND      = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    // Start bit + data bits + stop bit, each OVERSAMPLE ticks long.
    function automatic int frameTicks(input int dataWidth);
        return OVERSAMPLE * (dataWidth + 2);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: the first valid requester
// after last_grant (wrapping) wins.
module rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     last_grant,
    output logic [IDW-1:0]     winner,
    output logic               any
);

    int idx;

    // Walk from the farthest candidate to the nearest so the nearest valid one is kept.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (req_valid[idx[IDW-1:0]]) begin
                winner = idx[IDW-1:0];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// producers, with reset drain, frame watchdog and inter-frame idle gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int GAP_TICKS   = 16,
    parameter int FRAME_TICKS = frameTicks(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_in,
    input  logic                          tx_dv,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          tx_timeout
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(FRAME_TICKS + GAP_TICKS + 17);
    localparam logic [CW-1:0] HOLD_LAST = CW'(FRAME_TICKS + GAP_TICKS - 1);
    localparam logic [CW-1:0] WD_LAST   = CW'(FRAME_TICKS + 15);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         tickCnt_q, tickCnt_d;
    logic [IDW-1:0]        lastGrant_q, lastGrant_d;
    logic [IDW-1:0]        grantId_q, grantId_d;
    logic [DATA_WIDTH-1:0] txIn_q, txIn_d;
    logic [NUM_REQ-1:0]    reqReady_q, reqReady_d;
    logic                  txStart_q, txStart_d;
    logic                  timeout_q, timeout_d;
    logic [IDW-1:0]        winner;
    logic                  anyReq;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_picker (
        .req_valid (req_valid),
        .last_grant(lastGrant_q),
        .winner    (winner),
        .any       (anyReq)
    );

    always_comb begin
        state_d     = state_q;
        tickCnt_d   = tickCnt_q;
        lastGrant_d = lastGrant_q;
        grantId_d   = grantId_q;
        txIn_d      = txIn_q;
        reqReady_d  = '0;
        txStart_d   = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (tick) begin
                    if (tickCnt_q == HOLD_LAST) begin
                        state_d   = ST_IDLE;
                        tickCnt_d = '0;
                    end else begin
                        tickCnt_d = tickCnt_q + CW'(1);
                    end
                end
            end
            ST_IDLE: begin
                if (anyReq) begin
                    state_d             = ST_SEND;
                    txIn_d              = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    grantId_d           = winner;
                    lastGrant_d         = winner;
                    reqReady_d[winner]  = 1'b1;
                    txStart_d           = 1'b1;
                end
            end
            ST_SEND: begin
                state_d   = ST_WAIT_DONE;
                tickCnt_d = '0;
            end
            ST_WAIT_DONE: begin
                // A frame-done pulse beats a watchdog expiry on the same edge.
                if (tx_dv) begin
                    state_d   = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
                    tickCnt_d = '0;
                end else if (tick) begin
                    if (tickCnt_q == WD_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_GAP;
                        tickCnt_d = '0;
                    end else begin
                        tickCnt_d = tickCnt_q + CW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (GAP_TICKS == 0) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (tickCnt_q == GAP_LAST) begin
                        state_d   = ST_IDLE;
                        tickCnt_d = '0;
                    end else begin
                        tickCnt_d = tickCnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d   = ST_HOLD;
                tickCnt_d = '0;
            end
        endcase
    end

    // Reset parks in HOLD so a frame left running in the transmitter can drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            tickCnt_q   <= '0;
            lastGrant_q <= IDW'(NUM_REQ - 1);
            grantId_q   <= '0;
            txIn_q      <= '0;
            reqReady_q  <= '0;
            txStart_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tickCnt_q   <= tickCnt_d;
            lastGrant_q <= lastGrant_d;
            grantId_q   <= grantId_d;
            txIn_q      <= txIn_d;
            reqReady_q  <= reqReady_d;
            txStart_q   <= txStart_d;
            timeout_q   <= timeout_d;
        end
    end

    assign req_ready  = reqReady_q;
    assign tx_start   = txStart_q;
    assign tx_in      = txIn_q;
    assign grant_id   = grantId_q;
    assign tx_timeout = timeout_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
